// File: rtl/usb_phy_tx.sv
// usb_phy_tx: low/full-speed USB serial packet transmitter.
// Takes a valid/ready byte stream and adds SYNC, NRZI, bit stuffing and EOP on the D+/D- pair.
module usb_phy_tx #(
   parameter logic C_usb_speed   = 1'b0,
   parameter int   C_clk_per_bit = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       usb_dp,
   output logic       usb_dn,
   output logic       usb_oe,
   output logic       busy,
   output logic       underrun
);
   localparam int            PW     = (C_clk_per_bit > 1) ? $clog2(C_clk_per_bit) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(C_clk_per_bit - 1);

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

   state_t        state, state_n;
   logic [PW-1:0] pcnt, pcnt_n;
   logic [2:0]    bitcnt, bitcnt_n;
   logic          byte_done, byte_done_n;
   logic [2:0]    ones, ones_n;
   logic          lvl_j, lvl_n;
   logic [7:0]    shreg, shreg_n;
   logic          last_q, last_n;
   logic          oe_n, dp_n, dn_n, ready_n, busy_n, und_n;
   logic          xfer, boundary, send, bit_v, se0;

   function automatic logic line_dp(input logic is_se0, input logic is_j);
      return is_se0 ? 1'b0 : (is_j ? C_usb_speed : ~C_usb_speed);
   endfunction

   function automatic logic line_dn(input logic is_se0, input logic is_j);
      return is_se0 ? 1'b0 : (is_j ? ~C_usb_speed : C_usb_speed);
   endfunction

   always_comb begin
      state_n     = state;
      pcnt_n      = pcnt;
      bitcnt_n    = bitcnt;
      byte_done_n = byte_done;
      ones_n      = ones;
      lvl_n       = lvl_j;
      shreg_n     = shreg;
      last_n      = last_q;
      oe_n        = usb_oe;
      dp_n        = usb_dp;
      dn_n        = usb_dn;
      und_n       = 1'b0;
      send        = 1'b0;
      bit_v       = 1'b0;
      se0         = 1'b0;
      xfer        = tx_valid && tx_ready;
      boundary    = (pcnt == P_LAST);

      if (state != S_IDLE)
         pcnt_n = boundary ? '0 : pcnt + 1'b1;

      case (state)
         S_IDLE: begin
            oe_n  = 1'b0;
            lvl_n = 1'b1;
            dp_n  = line_dp(1'b0, 1'b1);
            dn_n  = line_dn(1'b0, 1'b1);
            if (xfer) begin
               shreg_n  = tx_data;
               last_n   = tx_last;
               state_n  = S_SYNC;
               pcnt_n   = P_LAST;
               bitcnt_n = 3'd0;
               ones_n   = 3'd0;
            end
         end
         S_SYNC: if (boundary) begin
            oe_n     = 1'b1;
            send     = 1'b1;
            bit_v    = (bitcnt == 3'd7);
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
               state_n     = S_DATA;
               byte_done_n = 1'b0;
            end
         end
         S_DATA: if (boundary) begin
            // A stuff bit owed takes priority over both data and the byte refill.
            if (ones == 3'd6) begin
               send = 1'b1;
            end else if (!byte_done) begin
               send        = 1'b1;
               bit_v       = shreg[bitcnt];
               bitcnt_n    = bitcnt + 3'd1;
               byte_done_n = (bitcnt == 3'd7);
            end else if (xfer) begin
               shreg_n     = tx_data;
               last_n      = tx_last;
               send        = 1'b1;
               bit_v       = tx_data[0];
               bitcnt_n    = 3'd1;
               byte_done_n = 1'b0;
            end else begin
               state_n  = S_EOP_SE0;
               se0      = 1'b1;
               bitcnt_n = 3'd0;
               und_n    = !last_q;
            end
         end
         S_EOP_SE0: if (boundary) begin
            if (bitcnt == 3'd0) begin
               bitcnt_n = 3'd1;
            end else begin
               state_n = S_EOP_J;
               lvl_n   = 1'b1;
               dp_n    = line_dp(1'b0, 1'b1);
               dn_n    = line_dn(1'b0, 1'b1);
            end
         end
         S_EOP_J: if (boundary) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
         end
         default: state_n = S_IDLE;
      endcase

      // NRZI: a 0 toggles the line, a 1 holds it; consecutive ones feed the stuffer.
      if (send) begin
         lvl_n  = bit_v ? lvl_j : ~lvl_j;
         ones_n = bit_v ? ((ones == 3'd6) ? 3'd6 : ones + 3'd1) : 3'd0;
         dp_n   = line_dp(1'b0, lvl_n);
         dn_n   = line_dn(1'b0, lvl_n);
      end
      if (se0) begin
         dp_n = 1'b0;
         dn_n = 1'b0;
      end

      ready_n = (state_n == S_IDLE) ||
                (state_n == S_DATA && pcnt_n == P_LAST && byte_done_n &&
                 ones_n != 3'd6 && !last_n);
      busy_n  = (state_n != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         pcnt      <= '0;
         bitcnt    <= 3'd0;
         byte_done <= 1'b0;
         ones      <= 3'd0;
         lvl_j     <= 1'b1;
         usb_oe    <= 1'b0;
         usb_dp    <= line_dp(1'b0, 1'b1);
         usb_dn    <= line_dn(1'b0, 1'b1);
         tx_ready  <= 1'b0;
         busy      <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_n;
         pcnt      <= pcnt_n;
         bitcnt    <= bitcnt_n;
         byte_done <= byte_done_n;
         ones      <= ones_n;
         lvl_j     <= lvl_n;
         usb_oe    <= oe_n;
         usb_dp    <= dp_n;
         usb_dn    <= dn_n;
         tx_ready  <= ready_n;
         busy      <= busy_n;
         underrun  <= und_n;
      end
   end

   always_ff @(posedge clk) begin
      shreg  <= shreg_n;
      last_q <= last_n;
   end

endmodule

// File: tb/tb_usb_phy_tx.sv
// Bench for usb_phy_tx: low- and full-speed instances share one stimulus stream;
// a packet-level model fills a scoreboard that a line monitor drains.
module tb_usb_phy_tx;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tx_valid, tx_last;
   logic [7:0] tx_data;
   logic       ls_ready, ls_dp, ls_dn, ls_oe, ls_busy, ls_und;
   logic       fs_ready, fs_dp, fs_dn, fs_oe, fs_busy, fs_und;

   always #5 clk = ~clk;

   usb_phy_tx #(.C_usb_speed(1'b0), .C_clk_per_bit(CPB)) dut_ls (
      .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
      .tx_ready(ls_ready), .usb_dp(ls_dp), .usb_dn(ls_dn), .usb_oe(ls_oe),
      .busy(ls_busy), .underrun(ls_und));

   usb_phy_tx #(.C_usb_speed(1'b1), .C_clk_per_bit(CPB)) dut_fs (
      .clk(clk), .rstn(rstn), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
      .tx_ready(fs_ready), .usb_dp(fs_dp), .usb_dn(fs_dn), .usb_oe(fs_oe),
      .busy(fs_busy), .underrun(fs_und));

   int n_chk = 0;
   int n_pass = 0;
   bit mon_en = 1'b0;
   logic [7:0] pkt [8];

   // Scoreboard: per packet a symbol count, its symbols (0=SE0,1=J,2=K),
   // the expected tx_ready pulse positions and the underrun position (-1 = none).
   int exp_len_q[$];
   int exp_sym_q[$];
   int exp_rdyn_q[$];
   int exp_rdy_q[$];
   int exp_und_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int sym_of(input logic dp, input logic dn, input logic spd);
      if (!dp && !dn) return 0;
      if (dp == spd && dn == !spd) return 1;
      if (dp == !spd && dn == spd) return 2;
      return 3;
   endfunction

   task automatic build_expect(input int nbytes, input bit und);
      int bits[$];
      int ends[$];
      int syms[$];
      int ones, lvl, v, nr;
      for (int i = 0; i < 8; i++) bits.push_back((i == 7) ? 1 : 0);
      ones = 1;
      for (int b = 0; b < nbytes; b++) begin
         for (int i = 0; i < 8; i++) begin
            v = (pkt[b] >> i) & 1;
            bits.push_back(v);
            ones = v ? ones + 1 : 0;
            if (ones == 6) begin
               bits.push_back(0);
               ones = 0;
            end
         end
         ends.push_back(bits.size() - 1);
      end
      lvl = 1;
      foreach (bits[i]) begin
         if (bits[i] == 0) lvl = 3 - lvl;
         syms.push_back(lvl);
      end
      syms.push_back(0);
      syms.push_back(0);
      syms.push_back(1);
      exp_len_q.push_back(syms.size());
      foreach (syms[i]) exp_sym_q.push_back(syms[i]);
      nr = und ? nbytes : nbytes - 1;
      exp_rdyn_q.push_back(nr);
      for (int i = 0; i < nr; i++) exp_rdy_q.push_back(ends[i]);
      exp_und_q.push_back(und ? syms.size() - 3 : -1);
   endtask

   task automatic check_packet();
      int n, e, g_ls, g_fs, ctl_ok, und_n, und_pos, nr, idx;
      int rd_pos[$];
      if (exp_len_q.size() == 0) begin
         chk("unexpected_packet", 1, 0);
         for (int c = 0; c < 1000 && ls_oe; c++) @(negedge clk);
         return;
      end
      n = exp_len_q.pop_front();
      und_n = 0;
      und_pos = -1;
      for (int s = 0; s < n; s++) begin
         e = exp_sym_q.pop_front();
         g_ls = e;
         g_fs = e;
         ctl_ok = 1;
         for (int j = 0; j < CPB; j++) begin
            if (s != 0 || j != 0) @(negedge clk);
            if (sym_of(ls_dp, ls_dn, 1'b0) != e) g_ls = sym_of(ls_dp, ls_dn, 1'b0);
            if (sym_of(fs_dp, fs_dn, 1'b1) != e) g_fs = sym_of(fs_dp, fs_dn, 1'b1);
            if (!ls_oe || !fs_oe || !ls_busy || !fs_busy) ctl_ok = 0;
            if (fs_ready != ls_ready || fs_und != ls_und) ctl_ok = 0;
            if (ls_ready) rd_pos.push_back(s * CPB + j);
            if (ls_und) begin
               und_n++;
               und_pos = s * CPB + j;
            end
         end
         chk($sformatf("ls_sym%0d", s), g_ls, e);
         chk($sformatf("fs_sym%0d", s), g_fs, e);
         chk($sformatf("oe_busy_sym%0d", s), ctl_ok, 1);
      end
      @(negedge clk);
      chk("oe_off", int'(ls_oe | fs_oe), 0);
      chk("busy_off", int'(ls_busy | fs_busy), 0);
      chk("idle_ready", int'(ls_ready & fs_ready), 1);
      chk("idle_line_ls", sym_of(ls_dp, ls_dn, 1'b0), 1);
      chk("idle_line_fs", sym_of(fs_dp, fs_dn, 1'b1), 1);
      nr = exp_rdyn_q.pop_front();
      chk("ready_pulses", rd_pos.size(), nr);
      for (int i = 0; i < nr; i++) begin
         idx = exp_rdy_q.pop_front();
         if (i < rd_pos.size()) chk("ready_pos", rd_pos[i], idx * CPB + CPB - 1);
      end
      e = exp_und_q.pop_front();
      chk("underrun_cnt", und_n, (e >= 0) ? 1 : 0);
      if (e >= 0) chk("underrun_pos", und_pos, e * CPB);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && ls_oe) check_packet();
      end
   end

   task automatic send_pkt(input int nbytes, input bit und);
      bit got;
      build_expect(nbytes, und);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      for (int i = 0; i < nbytes; i++) begin
         tx_valid = 1'b1;
         tx_data  = pkt[i];
         tx_last  = !und && (i == nbytes - 1);
         got = 1'b0;
         for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = ls_ready;
         end
         chk("xfer_wait", int'(got), 1);
         if (!got) break;
         @(posedge clk);
         #1;
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
         tx_last  = 1'($urandom);
      end
      got = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin
         @(negedge clk);
         got = !ls_busy;
      end
      chk("pkt_done", int'(got), 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_oe"}, int'(ls_oe | fs_oe), 0);
      chk({tag, "_busy"}, int'(ls_busy | fs_busy), 0);
      chk({tag, "_ready"}, int'(ls_ready | fs_ready), 0);
      chk({tag, "_und"}, int'(ls_und | fs_und), 0);
      chk({tag, "_line_ls"}, sym_of(ls_dp, ls_dn, 1'b0), 1);
      chk({tag, "_line_fs"}, sym_of(fs_dp, fs_dn, 1'b1), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      bit und;
      bit got;
      rstn     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      #22;
      chk_reset_vals("reset");
      @(negedge clk);
      rstn = 1'b1;
      #1 chk("ready_before_edge", int'(ls_ready), 0);
      @(posedge clk);
      #1 chk("ready_after_release", int'(ls_ready & fs_ready), 1);
      mon_en = 1'b1;

      pkt[0] = 8'hD2;
      send_pkt(1, 1'b0);
      pkt[0] = 8'hFF;
      send_pkt(1, 1'b0);
      pkt[0] = 8'hFC;
      send_pkt(1, 1'b0);
      pkt[0] = 8'h4B; pkt[1] = 8'h00; pkt[2] = 8'hFF; pkt[3] = 8'hFF;
      send_pkt(4, 1'b0);
      pkt[0] = 8'hA5; pkt[1] = 8'h5A;
      send_pkt(1, 1'b1);

      for (int p = 0; p < 20; p++) begin
         nb  = $urandom_range(1, 5);
         und = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < nb; i++)
            pkt[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
         send_pkt(nb, und);
      end

      // Abort a packet mid-DATA with an asynchronous reset.
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      tx_last  = 1'b0;
      @(negedge clk);
      got = ls_ready;
      chk("rst_test_ready", int'(got), 1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (15 * CPB) @(posedge clk);
      #3 rstn = 1'b0;
      #1 chk_reset_vals("midreset");
      repeat (3) @(negedge clk);
      chk("ready_held_in_reset", int'(ls_ready | fs_ready), 0);
      rstn = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_midreset", int'(ls_ready & fs_ready), 1);
      mon_en = 1'b1;
      pkt[0] = 8'h3F; pkt[1] = 8'hD2;
      send_pkt(2, 1'b0);

      for (int c = 0; c < 200 && exp_len_q.size() != 0; c++) @(negedge clk);
      chk("scoreboard_drained", exp_len_q.size(), 0);
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
